// File: rtl/tick_timer.sv
// Programmable periodic/one-shot tick generator with start/stop control and a global count enable.
// Define TICK_TIMER_PRESCALE_EN to insert a PRESCALE-cycle prescaler in front of the count.
module tick_timer #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             step;

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("tick_timer: PRESCALE must be in 1..65535");
    end

`ifdef TICK_TIMER_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] psc_q, psc_d;

    always_comb begin
        psc_d = psc_q;
        if (stop || start) begin
            psc_d = '0;
        end else if (state_q == S_RUN && en) begin
            psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) psc_q <= '0;
        else     psc_q <= psc_d;
    end

    assign step = (psc_q == PSC_LAST);
`else
    assign step = 1'b1;
`endif

    // stop outranks start; a restart discards any wrap due on the same edge
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (start) begin
            state_d  = S_RUN;
            count_d  = '0;
            period_d = (period == '0) ? WIDTH'(1) : period;
            mode_d   = oneshot;
        end else if (state_q == S_RUN && en && step) begin
            if (count_q == period_q - WIDTH'(1)) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (mode_q) state_d = S_DONE;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: an arithmetic step-count model checked every cycle plus literal checkpoints.
module tb_tick_timer;

`ifdef TICK_TIMER_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, en, start, stop, oneshot;
    logic [W-1:0] period;
    logic         tick, busy, done;
    logic [W-1:0] count;

    int checks = 0;
    int errors = 0;

    tick_timer #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .oneshot(oneshot), .period(period),
        .tick(tick), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: counts raw enabled RUN cycles since the last start/wrap; a tick is due
    // every P*PS such cycles, and the visible count is that total divided by PS.
    bit     m_run, m_fin, m_os, m_tick;
    longint m_P, m_steps;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_fin = 0; m_os = 0; m_tick = 0; m_P = 1; m_steps = 0;
        end else begin
            m_tick = 0;
            if (stop) begin
                m_run = 0; m_fin = 0; m_steps = 0;
            end else if (start) begin
                m_run = 1; m_fin = 0; m_steps = 0;
                m_P = (period == 0) ? 1 : longint'(period);
                m_os = oneshot;
            end else if (m_run && en) begin
                m_steps++;
                if (m_steps % (m_P * PS) == 0) begin
                    m_tick = 1;
                    m_steps = 0;
                    if (m_os) begin m_run = 0; m_fin = 1; end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("cmp_tick", tick, m_tick);
            chk("cmp_busy", busy, m_run);
            chk("cmp_done", done, m_fin);
            chk("cmp_count", count, m_run ? m_steps / PS : 0);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start(input int p, input bit os);
        start = 1; period = W'(p); oneshot = os;
        step();
        start = 0;
    endtask

    task automatic do_stop();
        stop = 1;
        step();
        stop = 0;
    endtask

    initial begin
        rst = 1; en = 1; start = 0; stop = 0; oneshot = 0; period = '0;
        repeat (2) step();
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        rst = 0;
        step();

        // 1: periodic, period 5
        do_start(5, 0);
        chk("t1_count0", count, 0);
        chk("t1_tick0", tick, 0);
        for (int k = 1; k <= 15 * PS; k++) begin
            step();
            chk("t1_tick", tick, (k % (5 * PS) == 0) ? 1 : 0);
            chk("t1_count", count, (k / PS) % 5);
            chk("t1_busy", busy, 1);
        end

        // 2: one-shot, period 3
        do_stop();
        do_start(3, 1);
        chk("t2_busy", busy, 1);
        for (int k = 1; k <= 3 * PS; k++) begin
            step();
            chk("t2_tick", tick, (k == 3 * PS) ? 1 : 0);
        end
        step();
        chk("t2_done", done, 1);
        chk("t2_busy_lo", busy, 0);
        chk("t2_count", count, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t2_quiet", tick, 0);
        end
        do_start(3, 1);
        chk("t2_done_clr", done, 0);
        repeat (3 * PS) step();
        chk("t2_retick", tick, 1);
        step();
        chk("t2_retick_w", tick, 0);

        // 3: en low for 2 cycles at count 2, period 4
        do_stop();
        do_start(4, 0);
        repeat (2 * PS) step();
        chk("t3_count2", count, 2);
        en = 0;
        step();
        chk("t3_hold_a", count, 2);
        chk("t3_hold_tick", tick, 0);
        step();
        chk("t3_hold_b", count, 2);
        en = 1;
        repeat (2 * PS - 1) step();
        chk("t3_early", tick, 0);
        step();
        chk("t3_tick", tick, 1);
        chk("t3_wrap", count, 0);
        step();
        chk("t3_width", tick, 0);

        // 4: period 0 and period 1
        do_stop();
        do_start(0, 0);
        chk("t4_p0_tick0", tick, 0);
        for (int k = 1; k <= 4 * PS; k++) begin
            step();
            chk("t4_p0_tick", tick, (k % PS == 0) ? 1 : 0);
            chk("t4_p0_count", count, 0);
        end
        do_start(1, 0);
        chk("t4_p1_tick0", tick, 0);
        for (int k = 1; k <= 4 * PS; k++) begin
            step();
            chk("t4_p1_tick", tick, (k % PS == 0) ? 1 : 0);
            chk("t4_p1_count", count, 0);
        end

        // 5: start+stop together, then restart alone at count 3
        do_stop();
        do_start(4, 0);
        repeat (3 * PS) step();
        chk("t5_count3", count, 3);
        start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        chk("t5_ss_tick", tick, 0);
        chk("t5_ss_busy", busy, 0);
        chk("t5_ss_count", count, 0);
        do_start(4, 0);
        repeat (3 * PS) step();
        chk("t5_count3b", count, 3);
        do_start(2, 0);
        chk("t5_rs_tick", tick, 0);
        chk("t5_rs_count", count, 0);
        repeat (2 * PS - 1) step();
        chk("t5_rs_early", tick, 0);
        step();
        chk("t5_rs_next", tick, 1);

        // 6: reset mid-run at count 7, then first tick of period 2
        do_stop();
        do_start(8, 0);
        repeat (7 * PS) step();
        chk("t6_count7", count, 7);
        #2 rst = 1;
        #1;
        chk("t6_rst_tick", tick, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", count, 0);
        step();
        rst = 0;
        step();
        chk("t6_post_tick", tick, 0);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_done", done, 0);
        do_start(2, 0);
        repeat (2 * PS - 1) step();
        chk("t6_early", tick, 0);
        step();
        chk("t6_first_tick", tick, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
